// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates LSB over ICache, splits/assembles little-endian words.
// Optional IO-store stall on a full UART buffer is enabled by defining MEMCTRL_IO_STALL_EN.
module mem_ctrl #(
  parameter logic [31:0] IO_BASE = 32'h0003_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clr_i,
  input  logic        io_buffer_full_i,
  input  logic        inst_en_i,
  input  logic [31:0] inst_addr_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  input  logic        ls_en_i,
  input  logic        ls_wr_i,
  input  logic [2:0]  ls_len_i,
  input  logic [31:0] ls_addr_i,
  input  logic [31:0] ls_data_i,
  output logic        ls_valid_o,
  output logic [31:0] ls_data_o,
  input  logic [7:0]  mem_din_i,
  output logic [7:0]  mem_dout_o,
  output logic [31:0] mem_a_o,
  output logic        mem_wr_o
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      state;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [31:0] rbuf;
  logic [2:0]  len_q;
  logic [2:0]  k;
  logic        inst_own;
  logic        is_wr;
  logic        io_q;
  logic        inst_vld_q;
  logic        ls_vld_q;
  logic        mem_wr_q;
  logic [31:0] inst_q;
  logic [31:0] ls_data_q;
  logic [2:0]  k_nxt;
  logic [1:0]  cap_idx;
  logic [1:0]  nxt_idx;
  logic [31:0] rd_word;
  logic        ls_blocked;
  logic        wr_stall;

`ifdef MEMCTRL_IO_STALL_EN
  assign ls_blocked = ls_wr_i && (ls_addr_i >= IO_BASE) && io_buffer_full_i;
  assign wr_stall   = (state == WRITE) && io_q && io_buffer_full_i;
`else
  logic unused_io;
  assign unused_io  = io_buffer_full_i ^ io_q;
  assign ls_blocked = 1'b0;
  assign wr_stall   = 1'b0;
`endif

  assign k_nxt   = k + 3'd1;
  assign nxt_idx = k_nxt[1:0];
  // RAM answers one cycle late, so while address k is out we capture byte k-1
  assign cap_idx = k[1:0] - 2'd1;

  always_comb begin
    rd_word = rbuf;
    rd_word[{cap_idx, 3'b000} +: 8] = mem_din_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr_q     <= 32'd0;
      data_q     <= 32'd0;
      rbuf       <= 32'd0;
      len_q      <= 3'd0;
      k          <= 3'd0;
      inst_own   <= 1'b0;
      is_wr      <= 1'b0;
      io_q       <= 1'b0;
      inst_vld_q <= 1'b0;
      ls_vld_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      inst_q     <= 32'd0;
      ls_data_q  <= 32'd0;
      mem_a_o    <= 32'd0;
      mem_dout_o <= 8'd0;
    end else if (rdy) begin
      case (state)
        IDLE: begin
          if (!clr_i) begin
            if (ls_en_i && !ls_blocked) begin
              addr_q   <= ls_addr_i;
              len_q    <= ls_len_i;
              data_q   <= ls_data_i;
              k        <= 3'd0;
              inst_own <= 1'b0;
              is_wr    <= ls_wr_i;
              io_q     <= (ls_addr_i >= IO_BASE);
              rbuf     <= 32'd0;
              mem_a_o  <= ls_addr_i;
              if (ls_wr_i) begin
                state      <= WRITE;
                mem_wr_q   <= 1'b1;
                mem_dout_o <= ls_data_i[7:0];
              end else begin
                state <= READ;
              end
            end else if (inst_en_i) begin
              addr_q   <= inst_addr_i;
              len_q    <= 3'd4;
              k        <= 3'd0;
              inst_own <= 1'b1;
              is_wr    <= 1'b0;
              io_q     <= 1'b0;
              rbuf     <= 32'd0;
              mem_a_o  <= inst_addr_i;
              state    <= READ;
            end
          end
        end
        READ: begin
          if (clr_i) begin
            state   <= IDLE;
            mem_a_o <= 32'd0;
          end else begin
            if (k != 3'd0) rbuf <= rd_word;
            if (k == len_q) begin
              state <= DONE;
              if (inst_own) begin
                inst_vld_q <= 1'b1;
                inst_q     <= rd_word;
              end else begin
                ls_vld_q  <= 1'b1;
                ls_data_q <= rd_word;
              end
            end else begin
              k       <= k_nxt;
              mem_a_o <= (k_nxt < len_q) ? addr_q + {29'd0, k_nxt} : 32'd0;
            end
          end
        end
        WRITE: begin
          // a store is never aborted by a flush; only the IO stall can pause it
          if (!wr_stall) begin
            if (k_nxt == len_q) begin
              state      <= DONE;
              ls_vld_q   <= 1'b1;
              ls_data_q  <= 32'd0;
              mem_wr_q   <= 1'b0;
              mem_a_o    <= 32'd0;
              mem_dout_o <= 8'd0;
            end else begin
              k          <= k_nxt;
              mem_a_o    <= addr_q + {29'd0, k_nxt};
              mem_dout_o <= data_q[{nxt_idx, 3'b000} +: 8];
            end
          end
        end
        DONE: begin
          state      <= IDLE;
          inst_vld_q <= 1'b0;
          ls_vld_q   <= 1'b0;
          inst_q     <= 32'd0;
          ls_data_q  <= 32'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // a flush in the DONE cycle of a read suppresses the pulse already queued
  assign inst_valid_o = inst_vld_q && !clr_i;
  assign inst_o       = inst_valid_o ? inst_q : 32'd0;
  assign ls_valid_o   = ls_vld_q && !(clr_i && !is_wr);
  assign ls_data_o    = ls_valid_o ? ls_data_q : 32'd0;
  assign mem_wr_o     = mem_wr_q && !wr_stall;

endmodule
